// File: rtl/control_pkg.sv
// Shared constants for the hardwired control unit: opcodes, ALU codes,
// datapath bit maps, step encoding and per-opcode step-sequencing helpers.
package control_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                         OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                         OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                         OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11,
                         OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14,
                         OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17,
                         OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20,
                         OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26,
                         OP_HALT = 5'd27;

  localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_AND = 6'd2,
                         ALU_OR  = 6'd3, ALU_SHR = 6'd4, ALU_SHRA = 6'd5,
                         ALU_SHL = 6'd6, ALU_ROR = 6'd7, ALU_ROL = 6'd8,
                         ALU_MUL = 6'd9, ALU_DIV = 6'd10, ALU_NEG = 6'd11,
                         ALU_NOT = 6'd12;

  localparam int EN_HI = 16, EN_LO = 17, EN_ZHI = 18, EN_ZLO = 19, EN_PC = 20,
                 EN_IR = 21, EN_MDR = 22, EN_MAR = 23, EN_Y = 24;

  localparam int I_HI = 16, I_LO = 17, I_ZHI = 18, I_ZLO = 19, I_PC = 20,
                 I_MDR = 22, I_C = 25;

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_e;

  // Final execute step of each opcode; undefined opcodes end at T3 like nop.
  function automatic state_e last_step(input logic [4:0] op);
    if (op >= OP_ADD && op <= OP_ORI) return T5;
    case (op)
      OP_LD, OP_ST:           return T7;
      OP_LDI:                 return T5;
      OP_MUL, OP_DIV, OP_BR:  return T6;
      OP_NEG, OP_NOT:         return T4;
      default:                return T3;
    endcase
  endfunction

  function automatic state_e next_step(input state_e s);
    case (s)
      T0:      return T1;
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      T6:      return T7;
      default: return T0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_to_alu_sel.sv
// Combinational opcode -> ALU operation map for the arithmetic/logic opcodes.
module opcode_to_alu_sel
  import control_pkg::*;
(
  input  logic [4:0] i_op,
  output logic [5:0] o_alu_sel
);

  always_comb begin
    o_alu_sel = ALU_ADD;
    case (i_op)
      OP_SUB:          o_alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: o_alu_sel = ALU_AND;
      OP_OR,  OP_ORI:  o_alu_sel = ALU_OR;
      OP_SHR:          o_alu_sel = ALU_SHR;
      OP_SHRA:         o_alu_sel = ALU_SHRA;
      OP_SHL:          o_alu_sel = ALU_SHL;
      OP_ROR:          o_alu_sel = ALU_ROR;
      OP_ROL:          o_alu_sel = ALU_ROL;
      OP_MUL:          o_alu_sel = ALU_MUL;
      OP_DIV:          o_alu_sel = ALU_DIV;
      OP_NEG:          o_alu_sel = ALU_NEG;
      OP_NOT:          o_alu_sel = ALU_NOT;
      default:         o_alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired step sequencer: fetch T0-T2, opcode-specific execute T3-T7,
// memory-ready stalls, and halt at instruction boundaries.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPW       = 5,
  parameter bit START_RUN = 1'b1
)(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [31:0] i,
  output logic [31:0] reg_enable,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        conIn,
  output logic        ConFFout,
  output logic        run
);

  state_e      r_state, w_next;
  logic        r_ena, r_stop_pend;
  logic [4:0]  w_op;
  logic [5:0]  w_alu;
  logic        w_rr, w_imm, w_md, w_nn, w_wait, w_boundary, w_unused;

  assign w_op     = 5'(ir[31 -: OPW]);
  assign w_unused = ^ir[31-OPW:0];
  assign w_rr     = (w_op >= OP_ADD)  && (w_op <= OP_SHL);
  assign w_imm    = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
  assign w_md     = (w_op == OP_MUL)  || (w_op == OP_DIV);
  assign w_nn     = (w_op == OP_NEG)  || (w_op == OP_NOT);
  assign w_wait   = !mem_ready && (((r_state == T6) && (w_op == OP_LD)) ||
                                   ((r_state == T7) && (w_op == OP_ST)));
  assign w_boundary = (r_state >= T3) && (r_state != HALT) && !w_wait &&
                      (r_state == last_step(w_op));

  opcode_to_alu_sel u_alu_map (.i_op(w_op), .o_alu_sel(w_alu));

  // r_ena masks outputs for the first cycle after reset so reset reads as all-zero.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= START_RUN ? T0 : HALT;
      r_ena       <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_ena <= 1'b1;
      if (r_ena) r_state <= w_next;
      if (r_ena && r_state != HALT)
        r_stop_pend <= w_boundary ? 1'b0 : (r_stop_pend | stop);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALT:    w_next = HALT;
      T0, T2:  w_next = next_step(r_state);
      T1:      w_next = mem_ready ? T2 : T1;
      default: begin
        if (w_op == OP_HALT)   w_next = HALT;
        else if (w_wait)       w_next = r_state;
        else if (w_boundary)   w_next = (stop || r_stop_pend) ? HALT : T0;
        else                   w_next = next_step(r_state);
      end
    endcase
  end

  always_comb begin
    i = '0; reg_enable = '0; ALU_Sel = ALU_ADD;
    read = 1'b0; write = 1'b0; incPC = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; conIn = 1'b0; ConFFout = 1'b0;
    run = r_ena ? (r_state != HALT) : START_RUN;
    if (r_ena) begin
      case (r_state)
        T0: begin i[I_PC] = 1'b1; reg_enable[EN_MAR] = 1'b1; incPC = 1'b1; end
        T1: begin read = 1'b1; reg_enable[EN_MDR] = 1'b1; end
        T2: begin i[I_MDR] = 1'b1; reg_enable[EN_IR] = 1'b1; end
        T3: begin
          if (w_rr || w_imm) begin Grb = 1'b1; Rout = 1'b1; reg_enable[EN_Y] = 1'b1; end
          else if (w_md)     begin Gra = 1'b1; Rout = 1'b1; reg_enable[EN_Y] = 1'b1; end
          else if (w_nn)     begin Grb = 1'b1; Rout = 1'b1; ALU_Sel = w_alu; reg_enable[EN_ZLO] = 1'b1; end
          else if (w_op == OP_LD || w_op == OP_LDI || w_op == OP_ST)
                             begin Grb = 1'b1; BAout = 1'b1; reg_enable[EN_Y] = 1'b1; end
          else if (w_op == OP_BR)   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
          else if (w_op == OP_JR)   begin Gra = 1'b1; Rout = 1'b1; reg_enable[EN_PC] = 1'b1; end
          else if (w_op == OP_MFHI) begin i[I_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (w_op == OP_MFLO) begin i[I_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        end
        T4: begin
          if (w_rr)       begin Grc = 1'b1; Rout = 1'b1; ALU_Sel = w_alu; reg_enable[EN_ZLO] = 1'b1; end
          else if (w_imm) begin i[I_C] = 1'b1; ALU_Sel = w_alu; reg_enable[EN_ZLO] = 1'b1; end
          else if (w_md)  begin Grb = 1'b1; Rout = 1'b1; ALU_Sel = w_alu;
                                reg_enable[EN_ZHI] = 1'b1; reg_enable[EN_ZLO] = 1'b1; end
          else if (w_nn)  begin i[I_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (w_op == OP_LD || w_op == OP_LDI || w_op == OP_ST)
                          begin i[I_C] = 1'b1; reg_enable[EN_ZLO] = 1'b1; end
          else if (w_op == OP_BR) begin i[I_PC] = 1'b1; reg_enable[EN_Y] = 1'b1; end
        end
        T5: begin
          if (w_rr || w_imm || w_op == OP_LDI) begin i[I_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (w_md) begin i[I_ZLO] = 1'b1; reg_enable[EN_LO] = 1'b1; end
          else if (w_op == OP_LD || w_op == OP_ST) begin i[I_ZLO] = 1'b1; reg_enable[EN_MAR] = 1'b1; end
          else if (w_op == OP_BR) begin i[I_C] = 1'b1; reg_enable[EN_ZLO] = 1'b1; end
        end
        T6: begin
          if (w_md)                begin i[I_ZHI] = 1'b1; reg_enable[EN_HI] = 1'b1; end
          else if (w_op == OP_LD)  begin read = 1'b1; reg_enable[EN_MDR] = 1'b1; end
          else if (w_op == OP_ST)  begin Gra = 1'b1; Rout = 1'b1; reg_enable[EN_MDR] = 1'b1; end
          else if (w_op == OP_BR)  begin i[I_ZLO] = 1'b1; reg_enable[EN_PC] = con_ff; end
        end
        T7: begin
          if (w_op == OP_LD)      begin i[I_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (w_op == OP_ST) write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, fetch, several instruction
// classes, memory stalls, branch condition, stop/halt and mid-instruction reset.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, con_ff, mem_ready, stop;
  logic [31:0] ir;
  logic [31:0] i, reg_enable;
  logic [5:0]  ALU_Sel;
  logic        read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, ConFFout, run;
  logic [11:0] str;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [11:0] S_RUN = 12'h001, S_CFO = 12'h002, S_CIN = 12'h004,
                          S_BA  = 12'h008, S_ROUT = 12'h010, S_RIN = 12'h020,
                          S_GC  = 12'h040, S_GB  = 12'h080, S_GA  = 12'h100,
                          S_INC = 12'h200, S_WR  = 12'h400, S_RD  = 12'h800;

  control_sequencer #(.OPW(5), .START_RUN(1'b1)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .i(i), .reg_enable(reg_enable), .ALU_Sel(ALU_Sel), .read(read), .write(write),
    .incPC(incPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .conIn(conIn), .ConFFout(ConFFout), .run(run)
  );

  assign str = {read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, ConFFout, run};

  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] ei, input logic [31:0] ee,
                     input logic [5:0] ea, input logic [11:0] es);
    ncmp++;
    assert (i === ei && reg_enable === ee && ALU_Sel === ea && str === es) else begin
      nerr++;
      $error("FAIL %s: got i=%h en=%h alu=%0d str=%b, expected i=%h en=%h alu=%0d str=%b",
             tag, i, reg_enable, ALU_Sel, str, ei, ee, ea, es);
    end
  endtask

  // Checks T0..T2 of fetch (mem_ready assumed high) and leaves the DUT in T3.
  task automatic fetch(input string tag);
    chk({tag, "_t0"}, b(20), b(23), 6'd0, S_RUN | S_INC);
    tick();
    chk({tag, "_t1"}, 32'd0, b(22), 6'd0, S_RUN | S_RD);
    tick();
    chk({tag, "_t2"}, b(22), b(21), 6'd0, S_RUN);
    tick();
  endtask

  initial begin
    clr = 1'b0; ir = 32'd0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
    tick(); tick();
    chk("reset", 32'd0, 32'd0, 6'd0, S_RUN);

    // add
    clr = 1'b1; ir = 32'h18A20000;
    tick();
    fetch("add");
    chk("add_t3", 32'd0, b(24), 6'd0, S_RUN | S_GB | S_ROUT);
    tick(); chk("add_t4", 32'd0, b(19), 6'd0, S_RUN | S_GC | S_ROUT);
    tick(); chk("add_t5", b(19), 32'd0, 6'd0, S_RUN | S_GA | S_RIN);
    tick();

    // sub: checks ALU code mapping
    ir = 32'h20000000;
    fetch("sub");
    tick(); chk("sub_t4", 32'd0, b(19), 6'd1, S_RUN | S_GC | S_ROUT);
    tick(); tick();

    // ld with a 3-cycle memory stall at T6
    ir = 32'h00000000;
    fetch("ld");
    chk("ld_t3", 32'd0, b(24), 6'd0, S_RUN | S_GB | S_BA);
    tick(); chk("ld_t4", b(25), b(19), 6'd0, S_RUN);
    tick(); chk("ld_t5", b(19), b(23), 6'd0, S_RUN);
    mem_ready = 1'b0;
    tick(); chk("ld_t6_c1", 32'd0, b(22), 6'd0, S_RUN | S_RD);
    tick(); chk("ld_t6_c2", 32'd0, b(22), 6'd0, S_RUN | S_RD);
    tick(); chk("ld_t6_c3", 32'd0, b(22), 6'd0, S_RUN | S_RD);
    tick(); chk("ld_t6_c4", 32'd0, b(22), 6'd0, S_RUN | S_RD);
    mem_ready = 1'b1;
    tick(); chk("ld_t7", b(22), 32'd0, 6'd0, S_RUN | S_GA | S_RIN);
    tick();

    // br not taken, then taken
    ir = 32'h98000000; con_ff = 1'b0;
    fetch("brn");
    chk("brn_t3", 32'd0, 32'd0, 6'd0, S_RUN | S_GA | S_ROUT | S_CIN);
    tick(); chk("brn_t4", b(20), b(24), 6'd0, S_RUN);
    tick(); chk("brn_t5", b(25), b(19), 6'd0, S_RUN);
    tick(); chk("brn_t6", b(19), 32'd0, 6'd0, S_RUN);
    tick();
    con_ff = 1'b1;
    fetch("brt");
    tick(); tick(); tick();
    chk("brt_t6", b(19), b(20), 6'd0, S_RUN);
    tick();
    con_ff = 1'b0;

    // mul with stop pulsed in T4: finishes, then halts
    ir = 32'h78000000;
    fetch("mul");
    chk("mul_t3", 32'd0, b(24), 6'd0, S_RUN | S_GA | S_ROUT);
    tick(); chk("mul_t4", 32'd0, b(18) | b(19), 6'd9, S_RUN | S_GB | S_ROUT);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("mul_t5", b(19), b(17), 6'd0, S_RUN);
    tick(); chk("mul_t6", b(18), b(16), 6'd0, S_RUN);
    tick(); chk("halt", 32'd0, 32'd0, 6'd0, 12'h000);
    tick(); chk("halt_hold", 32'd0, 32'd0, 6'd0, 12'h000);

    // reset leaves HALT
    clr = 1'b0;
    tick(); chk("reset2", 32'd0, 32'd0, 6'd0, S_RUN);
    clr = 1'b1;
    tick();

    // st, stalled at T7, then aborted by reset
    ir = 32'h10000000;
    fetch("st");
    chk("st_t3", 32'd0, b(24), 6'd0, S_RUN | S_GB | S_BA);
    tick();
    tick(); chk("st_t5", b(19), b(23), 6'd0, S_RUN);
    tick(); chk("st_t6", 32'd0, b(22), 6'd0, S_RUN | S_GA | S_ROUT);
    mem_ready = 1'b0;
    tick(); chk("st_t7", 32'd0, 32'd0, 6'd0, S_RUN | S_WR);
    tick(); chk("st_stall", 32'd0, 32'd0, 6'd0, S_RUN | S_WR);
    clr = 1'b0;
    tick(); chk("st_abort", 32'd0, 32'd0, 6'd0, S_RUN);
    clr = 1'b1; mem_ready = 1'b1;
    tick();

    // halt opcode
    ir = 32'hD8000000;
    fetch("hlt");
    chk("hlt_t3", 32'd0, 32'd0, 6'd0, S_RUN);
    tick(); chk("hlt_state", 32'd0, 32'd0, 6'd0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
